// File: rtl/nexys_starship_pkg.sv
// Shared encodings for the starship monster controller:
// side indices, slot and game state codes, kill popcount.
package nexys_starship_pkg;

   localparam int SIDE_TOP   = 3;
   localparam int SIDE_BTM   = 2;
   localparam int SIDE_LEFT  = 1;
   localparam int SIDE_RIGHT = 0;

   localparam logic [1:0] SLOT_EMPTY = 2'd0;
   localparam logic [1:0] SLOT_ALIVE = 2'd1;
   localparam logic [1:0] SLOT_COOL  = 2'd2;

   localparam logic [1:0] GAME_IDLE = 2'd0;
   localparam logic [1:0] GAME_PLAY = 2'd1;
   localparam logic [1:0] GAME_OVER = 2'd2;

   function automatic logic [2:0] popcnt4(input logic [3:0] v);
      return {2'b00, v[0]} + {2'b00, v[1]} +
             {2'b00, v[2]} + {2'b00, v[3]};
   endfunction

endpackage

// File: rtl/nexys_starship_monster_slot.sv
// One monster slot: EMPTY/ALIVE/COOL FSM with a tick counter.
// Kill and expire are same-cycle events consumed by the top level.
module nexys_starship_monster_slot
   import nexys_starship_pkg::*;
#(
   parameter int LIFE_TICKS     = 8,
   parameter int COOLDOWN_TICKS = 3,
   parameter int CNT_W          = 4
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_clr,
   input  logic i_play,
   input  logic i_tick,
   input  logic i_spawn,
   input  logic i_shoot,
   output logic o_active,
   output logic o_kill,
   output logic o_expire
);

   localparam logic [CNT_W-1:0] LIFE = CNT_W'(LIFE_TICKS);
   localparam logic [CNT_W-1:0] COOL = CNT_W'(COOLDOWN_TICKS);
   localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

   logic [1:0]       r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             w_alive;

   assign w_alive  = (r_state == SLOT_ALIVE);
   assign o_active = w_alive;
   // A shot always beats an expiring tick in the same cycle.
   assign o_kill   = i_play & w_alive & i_shoot;
   assign o_expire = i_play & w_alive & ~i_shoot &
                     i_tick & (r_cnt == ONE);

   // Slot FSM; frozen outside PLAY so the killer stays on screen.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= SLOT_EMPTY;
         r_cnt   <= '0;
      end else if (i_clr) begin
         r_state <= SLOT_EMPTY;
         r_cnt   <= '0;
      end else if (i_play) begin
         unique case (r_state)
            SLOT_EMPTY: begin
               if (i_spawn) begin
                  r_state <= SLOT_ALIVE;
                  r_cnt   <= LIFE;
               end
            end
            SLOT_ALIVE: begin
               if (i_shoot) begin
                  r_state <= (COOL == '0) ? SLOT_EMPTY
                                          : SLOT_COOL;
                  r_cnt   <= COOL;
               end else if (i_tick) begin
                  r_cnt <= r_cnt - ONE;
               end
            end
            SLOT_COOL: begin
               if (i_tick) begin
                  if (r_cnt <= ONE) begin
                     r_state <= SLOT_EMPTY;
                     r_cnt   <= '0;
                  end else begin
                     r_cnt <= r_cnt - ONE;
                  end
               end
            end
            default: begin
               r_state <= SLOT_EMPTY;
               r_cnt   <= '0;
            end
         endcase
      end
   end

endmodule

// File: rtl/nexys_starship_monster_ctrl.sv
// Monster controller top: four slots, game FSM,
// registered kill pulses and saturating score.
module nexys_starship_monster_ctrl
   import nexys_starship_pkg::*;
#(
   parameter int LIFE_TICKS     = 8,
   parameter int COOLDOWN_TICKS = 3,
   parameter int CNT_W          = 4,
   parameter int SCORE_W        = 8
) (
   input  logic               Clk,
   input  logic               Reset,
   input  logic               start,
   input  logic               tick,
   input  logic [3:0]         spawn_req,
   input  logic [3:0]         shoot,
   output logic [3:0]         monster_active,
   output logic [3:0]         kill_pulse,
   output logic [SCORE_W-1:0] score,
   output logic               playing,
   output logic               game_over
);

   localparam int SW = SCORE_W + 3;
   localparam logic [SW-1:0] SMAX = SW'((2**SCORE_W) - 1);
   localparam int SIDES [4] =
      '{SIDE_RIGHT, SIDE_LEFT, SIDE_BTM, SIDE_TOP};

   logic [1:0]         r_game;
   logic [3:0]         r_kill;
   logic [SCORE_W-1:0] r_score;
   logic               w_play;
   logic [3:0]         w_active;
   logic [3:0]         w_kill;
   logic [3:0]         w_expire;
   logic [SW-1:0]      w_sum;
   logic [SCORE_W-1:0] w_score_nxt;

   assign w_play = (r_game == GAME_PLAY);

   for (genvar g = 0; g < 4; g++) begin : g_slot
      nexys_starship_monster_slot #(
         .LIFE_TICKS     (LIFE_TICKS),
         .COOLDOWN_TICKS (COOLDOWN_TICKS),
         .CNT_W          (CNT_W)
      ) u_slot (
         .i_clk    (Clk),
         .i_rst_n  (Reset),
         .i_clr    (start),
         .i_play   (w_play),
         .i_tick   (tick),
         .i_spawn  (spawn_req[SIDES[g]]),
         .i_shoot  (shoot[SIDES[g]]),
         .o_active (w_active[SIDES[g]]),
         .o_kill   (w_kill[SIDES[g]]),
         .o_expire (w_expire[SIDES[g]])
      );
   end

   assign w_sum = {3'b000, r_score} + SW'(popcnt4(w_kill));
   assign w_score_nxt = (w_sum > SMAX) ? SMAX[SCORE_W-1:0]
                                       : w_sum[SCORE_W-1:0];

   // Game FSM; kills in the expiring cycle still score.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         r_game  <= GAME_IDLE;
         r_kill  <= '0;
         r_score <= '0;
      end else if (start) begin
         r_game  <= GAME_PLAY;
         r_kill  <= '0;
         r_score <= '0;
      end else begin
         r_kill  <= w_kill;
         r_score <= w_score_nxt;
         if (w_play && (|w_expire))
            r_game <= GAME_OVER;
      end
   end

   assign monster_active = w_active;
   assign kill_pulse     = r_kill;
   assign score          = r_score;
   assign playing        = (r_game == GAME_PLAY);
   assign game_over      = (r_game == GAME_OVER);

endmodule

// File: tb/tb_nexys_starship_monster_ctrl.sv
// Self-checking bench: two DUTs (SCORE_W 8 and 3) on shared
// stimulus, checked against a side-by-side game model.
module tb_nexys_starship_monster_ctrl;

   localparam int LIFE = 8;
   localparam int COOL = 3;

   logic       Clk = 1'b0;
   logic       Reset;
   logic       start;
   logic       tick;
   logic [3:0] spawn_req;
   logic [3:0] shoot;

   logic [3:0] ma_a, kp_a, ma_b, kp_b;
   logic [7:0] sc_a;
   logic [2:0] sc_b;
   logic       pl_a, go_a, pl_b, go_b;

   int n_vec = 0;
   int n_err = 0;

   // model: 0 idle, 1 play, 2 over
   int       m_mode;
   bit [3:0] m_alive;
   bit [3:0] m_kill;
   int       m_life [4];
   int       m_cool [4];
   int       m_total;

   logic [30:0] w_got;
   logic [30:0] w_exp;

   always #5 Clk = ~Clk;

   nexys_starship_monster_ctrl #(
      .LIFE_TICKS(LIFE), .COOLDOWN_TICKS(COOL),
      .CNT_W(4), .SCORE_W(8)
   ) u_dut (
      .Clk(Clk), .Reset(Reset), .start(start), .tick(tick),
      .spawn_req(spawn_req), .shoot(shoot),
      .monster_active(ma_a), .kill_pulse(kp_a), .score(sc_a),
      .playing(pl_a), .game_over(go_a)
   );

   nexys_starship_monster_ctrl #(
      .LIFE_TICKS(LIFE), .COOLDOWN_TICKS(COOL),
      .CNT_W(4), .SCORE_W(3)
   ) u_dut3 (
      .Clk(Clk), .Reset(Reset), .start(start), .tick(tick),
      .spawn_req(spawn_req), .shoot(shoot),
      .monster_active(ma_b), .kill_pulse(kp_b), .score(sc_b),
      .playing(pl_b), .game_over(go_b)
   );

   assign w_got = {ma_a, kp_a, sc_a, pl_a, go_a,
                   ma_b, kp_b, sc_b, pl_b, go_b};

   always_comb begin
      w_exp = '0;
      w_exp = {m_alive, m_kill,
               (m_total > 255) ? 8'd255 : 8'(m_total),
               m_mode == 1, m_mode == 2,
               m_alive, m_kill,
               (m_total > 7) ? 3'd7 : 3'(m_total),
               m_mode == 1, m_mode == 2};
   end

   function automatic void model_reset();
      m_mode  = 0;
      m_alive = '0;
      m_kill  = '0;
      m_total = 0;
      for (int i = 0; i < 4; i++) begin
         m_life[i] = 0;
         m_cool[i] = 0;
      end
   endfunction

   function automatic void model_step(bit st, bit tk,
                                      bit [3:0] sp, bit [3:0] sh);
      bit died;
      died = 1'b0;
      if (st) begin
         model_reset();
         m_mode = 1;
         return;
      end
      m_kill = '0;
      if (m_mode != 1) return;
      for (int i = 0; i < 4; i++) begin
         if (m_alive[i]) begin
            if (sh[i]) begin
               m_kill[i]  = 1'b1;
               m_alive[i] = 1'b0;
               m_cool[i]  = COOL;
               m_total++;
            end else if (tk) begin
               m_life[i]--;
               if (m_life[i] == 0) died = 1'b1;
            end
         end else if (m_cool[i] > 0) begin
            if (tk) m_cool[i]--;
         end else if (sp[i]) begin
            m_alive[i] = 1'b1;
            m_life[i]  = LIFE;
         end
      end
      if (died) m_mode = 2;
   endfunction

   task automatic apply(input bit st, input bit tk,
                        input bit [3:0] sp, input bit [3:0] sh);
      start     = st;
      tick      = tk;
      spawn_req = sp;
      shoot     = sh;
      @(posedge Clk);
      model_step(st, tk, sp, sh);
      #1;
      start     = 1'b0;
      tick      = 1'b0;
      spawn_req = '0;
      shoot     = '0;
   endtask

   task automatic test_reset();
      n_vec++;
      if (w_got !== w_exp) begin
         n_err++;
         $display("FAIL reset_init got=%h exp=%h", w_got, w_exp);
      end
      Reset = 1'b1;
      apply(1, 0, 4'b0000, 4'b0000);
      apply(0, 0, 4'b1111, 4'b0000);
      apply(0, 0, 4'b0000, 4'b1111);
      for (int k = 0; k < 3; k++) apply(0, 1, 4'b0000, 4'b0000);
      apply(0, 0, 4'b0001, 4'b0000);
      apply(0, 0, 4'b0000, 4'b0001);
      apply(0, 0, 4'b1100, 4'b0000);
      n_vec++;
      if (w_got !== w_exp || sc_a !== 8'd5) begin
         n_err++;
         $display("FAIL reset_setup got=%h exp=%h", w_got, w_exp);
      end
      #2;
      Reset = 1'b0;
      model_reset();
      #1;
      n_vec++;
      if (w_got !== w_exp) begin
         n_err++;
         $display("FAIL reset_async got=%h exp=%h", w_got, w_exp);
      end
      #2;
      Reset = 1'b1;
      apply(0, 1, 4'b1111, 4'b1111);
      n_vec++;
      if (w_got !== w_exp) begin
         n_err++;
         $display("FAIL reset_idle got=%h exp=%h", w_got, w_exp);
      end
   endtask

   task automatic test_expire();
      apply(1, 0, 4'b0000, 4'b0000);
      apply(0, 0, 4'b1000, 4'b0000);
      for (int k = 0; k < 8; k++) begin
         apply(0, 1, 4'b0000, 4'b0000);
         n_vec++;
         if (w_got !== w_exp) begin
            n_err++;
            $display("FAIL expire_tick%0d got=%h exp=%h",
                     k, w_got, w_exp);
         end
         apply(0, 0, 4'b0000, 4'($urandom_range(0, 7)));
         n_vec++;
         if (w_got !== w_exp) begin
            n_err++;
            $display("FAIL expire_gap%0d got=%h exp=%h",
                     k, w_got, w_exp);
         end
      end
   endtask

   task automatic test_multi_kill();
      apply(1, 0, 4'b0000, 4'b0000);
      apply(0, 0, 4'b1111, 4'b0000);
      apply(0, 0, 4'b0000, 4'b1111);
      n_vec++;
      if (w_got !== w_exp || kp_a !== 4'b1111) begin
         n_err++;
         $display("FAIL multi_kill got=%h exp=%h", w_got, w_exp);
      end
      for (int k = 0; k < 4; k++) begin
         apply(0, k < 3, 4'b1111, 4'($urandom));
         n_vec++;
         if (w_got !== w_exp) begin
            n_err++;
            $display("FAIL multi_cool%0d got=%h exp=%h",
                     k, w_got, w_exp);
         end
      end
   endtask

   task automatic test_simultaneous();
      apply(1, 0, 4'b0000, 4'b0000);
      apply(0, 0, 4'b0100, 4'b0000);
      for (int k = 0; k < 7; k++) apply(0, 1, 4'b0000, 4'b0000);
      apply(0, 1, 4'b0000, 4'b0100);
      n_vec++;
      if (w_got !== w_exp) begin
         n_err++;
         $display("FAIL sim_shoot_tick got=%h exp=%h", w_got, w_exp);
      end
      apply(1, 0, 4'b0000, 4'b0000);
      apply(0, 0, 4'b0011, 4'b0000);
      for (int k = 0; k < 7; k++) apply(0, 1, 4'b0000, 4'b0000);
      apply(0, 1, 4'b0000, 4'b0001);
      n_vec++;
      if (w_got !== w_exp) begin
         n_err++;
         $display("FAIL sim_kill_expire got=%h exp=%h", w_got, w_exp);
      end
   endtask

   task automatic test_over();
      for (int k = 0; k < 20; k++) begin
         apply(0, 1'($urandom), 4'($urandom), 4'($urandom));
         n_vec++;
         if (w_got !== w_exp) begin
            n_err++;
            $display("FAIL over_frozen%0d got=%h exp=%h",
                     k, w_got, w_exp);
         end
      end
      apply(1, 0, 4'b0000, 4'b0000);
      n_vec++;
      if (w_got !== w_exp) begin
         n_err++;
         $display("FAIL over_restart got=%h exp=%h", w_got, w_exp);
      end
   endtask

   task automatic test_saturate();
      apply(1, 0, 4'b0000, 4'b0000);
      for (int r = 0; r < 3; r++) begin
         apply(0, 0, 4'b1111, 4'b0000);
         apply(0, 0, 4'b0000, 4'b1111);
         for (int k = 0; k < 3; k++)
            apply(0, 1, 4'b0000, 4'($urandom));
         n_vec++;
         if (w_got !== w_exp) begin
            n_err++;
            $display("FAIL sat_round%0d got=%h exp=%h",
                     r, w_got, w_exp);
         end
      end
      apply(0, 0, 4'b0000, 4'b1111);
      n_vec++;
      if (w_got !== w_exp || sc_b !== 3'd7) begin
         n_err++;
         $display("FAIL sat_empty_shot got=%h exp=%h", w_got, w_exp);
      end
   endtask

   task automatic test_random();
      for (int k = 0; k < 3000; k++) begin
         apply($urandom_range(0, 63) == 0,
               $urandom_range(0, 2) == 0,
               4'($urandom) & 4'($urandom),
               4'($urandom) & 4'($urandom) & 4'($urandom));
         n_vec++;
         if (w_got !== w_exp) begin
            n_err++;
            $display("FAIL random%0d got=%h exp=%h",
                     k, w_got, w_exp);
         end
      end
   endtask

   initial begin
      Reset     = 1'b0;
      start     = 1'b0;
      tick      = 1'b0;
      spawn_req = '0;
      shoot     = '0;
      model_reset();
      #12;
      test_reset();
      test_expire();
      test_multi_kill();
      test_simultaneous();
      test_over();
      test_saturate();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==",
               n_vec, n_err);
      $finish;
   end

endmodule
